dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: RAM size in 32-bit words, power of two.
REQ-002 Parameter FIFO_DEPTH, default 8: console TX FIFO entries, power of two.
REQ-003 Port clk  input  1: clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port dmemAddr  input  32: byte address from the core M stage.
REQ-006 Port dmemWdata  input  32: store data, unshifted (rs2 value).
REQ-007 Port dmemSize  input  3: funct3 size code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 Port dmemWen  input  1: store strobe.
REQ-009 Port dmemRdata  output  32: load data, combinational.
REQ-010 Port cons_data  output  8: console byte at FIFO head.
REQ-011 Port cons_valid  output  1: FIFO non-empty.
REQ-012 Port cons_ready  input  1: console consumer accepts the head byte.
REQ-013 Port done  output  1: TOHOST written.
REQ-014 Port exit_code  output  8: low byte of the first TOHOST write.
REQ-015 Port err  output  3: sticky errors: bit0 misaligned store, bit1 unmapped or invalid-size store, bit2 FIFO overflow.

Function
REQ-016 Address map: RAM at 0x0000_0000..DEPTH_WORDS*4-1. MMIO decoded on addr[31:2], with byte lane ignored:
- 0x8000_0000 CONS: write pushes wdata[7:0]; read gives {24'b0, count[3:0], 2'b0, empty, full}.
- 0x8000_0004 MTIME_LO.
- 0x8000_0008 MTIME_HI.
- 0x8000_000C TOHOST.
- 0x8000_0010 ERR: read {29'b0, err}; any write clears err.
REQ-017 Reads are combinational with no side effects, reflecting state before the current edge.
REQ-018 RAM load extraction, lane = addr[1:0]:
- B/BU: byte at lane, sign- or zero-extended.
- H/HU: half at addr[1], sign- or zero-extended.
- W and codes 011/11x: full word.
REQ-019 A misaligned RAM read (H with addr[0]=1; W with addr[1:0]!=0) returns 0.
REQ-020 A read of an unmapped address returns 0.
REQ-021 MMIO reads return the full 32-bit register value regardless of size.
REQ-022 RAM store when dmemWen=1, on the rising edge, with byte enables:
- SB: wdata[7:0] written to lane addr[1:0].
- SH: wdata[15:0] written to the half at addr[1].
- SW: all four bytes written.
REQ-023 Misaligned store: no write; err[0] set.
REQ-024 Unmapped address, or size code 011/1xx on a store: no write; err[1] set.
REQ-025 MMIO stores accept sizes 000/001/010 and use wdata low bits; alignment is not checked.
REQ-026 Error set and ERR clear in the same cycle: the clear wins for existing bits; the new error bit is still set.
REQ-027 MTIME is 64 bits.
- Increments by 1 every cycle and wraps from 2^64-1 to 0.
- A write to LO or HI loads that half with wdata; the other half keeps its incremented value.
- The write beats the increment in that cycle.
REQ-028 FIFO pop when cons_valid & cons_ready; cons_data is the head byte, valid the same cycle.
REQ-029 FIFO push on a CONS write.
- If full and no pop that cycle: byte dropped, err[2] set.
- If full with a simultaneous pop: push accepted and count unchanged.
REQ-030 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-031 First TOHOST write: done<=1 and exit_code<=wdata[7:0], effective the next cycle.
REQ-032 Later TOHOST writes are ignored until reset.
REQ-033 Store-to-load visibility: a load in the cycle after a store sees the new data; no forwarding within the same cycle.

Reset
REQ-034 While rst=1: MTIME=0, FIFO empty (cons_valid=0), done=0, exit_code=0, err=0, and stores are ignored.
REQ-035 RAM contents are not reset.
REQ-036 Asserting rst mid-operation discards FIFO contents the next cycle.
REQ-037 MTIME reads 1 in the first cycle after rst deasserts.

Verification
REQ-038 Bench SHALL cover: SW 0x8765_43A1 to 0x100, then LB/LBU/LH/LHU at 0x100 -> 0xFFFF_FFA1, 0x0000_00A1, 0x0000_43A1, 0x0000_43A1; LB at 0x103 -> 0xFFFF_FF87.
REQ-039 Bench SHALL cover: SB 0x55 at 0x101 over 0x1122_3344 -> word reads 0x1122_5544.
REQ-040 Bench SHALL cover: SH to 0x101 -> RAM unchanged, err=001; then SW to 0x8000_0010 -> err=000.
REQ-041 Bench SHALL cover: with cons_ready=0, 9 CONS writes 0x41..0x49:
- CONS read shows count 8, full=1.
- err[2] set and 0x49 dropped.
- Then cons_ready=1 drains 0x41..0x48 in 8 cycles, after which cons_valid=0.
REQ-042 Bench SHALL cover: MTIME_LO write 0xFFFF_FFFF and MTIME_HI write 0 -> the next reads show LO=0 and HI=1 after wrap.
REQ-043 Bench SHALL cover: TOHOST writes 0x2A, then 0x07 -> done=1, exit_code=0x2A; after rst, done=0 and exit_code=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with byte-lane stores plus an MMIO block
// holding a console TX FIFO, a 64-bit MTIME counter, a TOHOST latch and sticky error flags.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  output logic [31:0] dmemRdata,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready,
  output logic        done,
  output logic [7:0]  exit_code,
  output logic [2:0]  err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] CONS_W   = 30'h2000_0000;
  localparam logic [29:0] MTLO_W   = 30'h2000_0001;
  localparam logic [29:0] MTHI_W   = 30'h2000_0002;
  localparam logic [29:0] TOHOST_W = 30'h2000_0003;
  localparam logic [29:0] ERR_W    = 30'h2000_0004;
  localparam logic [FW:0] FIFO_FULL = (FW+1)'(FIFO_DEPTH);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [FW-1:0] wrPtr, rdPtr;
  logic [FW:0]   fifoCount;
  logic [63:0]   mtime, mtimeInc;

  logic [1:0]    lane;
  logic [AW-1:0] wordIdx;
  logic          isRam, consHit, mtLoHit, mtHiHit, tohostHit, errHit, mmioHit;
  logic          sizeOk, misaligned, stEn;
  logic          ramWr, consWr, mtLoWr, mtHiWr, tohostWr, errClr;
  logic [2:0]    newErr;
  logic          fifoFull, pop, push;
  logic [3:0]    cntLow;
  logic [31:0]   ramWord, laneData;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [3:0]    byteEn;

  assign lane      = dmemAddr[1:0];
  assign wordIdx   = dmemAddr[AW+1:2];
  assign isRam     = (dmemAddr >> (AW + 2)) == 32'd0;
  assign consHit   = dmemAddr[31:2] == CONS_W;
  assign mtLoHit   = dmemAddr[31:2] == MTLO_W;
  assign mtHiHit   = dmemAddr[31:2] == MTHI_W;
  assign tohostHit = dmemAddr[31:2] == TOHOST_W;
  assign errHit    = dmemAddr[31:2] == ERR_W;
  assign mmioHit   = consHit | mtLoHit | mtHiHit | tohostHit | errHit;

  assign sizeOk     = (dmemSize == 3'b000) || (dmemSize == 3'b001) || (dmemSize == 3'b010);
  assign misaligned = ((dmemSize == 3'b001) && lane[0]) || ((dmemSize == 3'b010) && (lane != 2'b00));
  assign stEn       = dmemWen & ~rst;

  assign ramWr    = stEn & isRam & sizeOk & ~misaligned;
  assign consWr   = stEn & consHit & sizeOk;
  assign mtLoWr   = stEn & mtLoHit & sizeOk;
  assign mtHiWr   = stEn & mtHiHit & sizeOk;
  assign tohostWr = stEn & tohostHit & sizeOk;
  assign errClr   = stEn & errHit & sizeOk;

  assign fifoFull   = fifoCount == FIFO_FULL;
  assign cons_valid = fifoCount != '0;
  assign cons_data  = fifoMem[rdPtr];
  assign pop        = cons_valid & cons_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push       = consWr & (~fifoFull | pop);
  assign cntLow     = 4'(fifoCount);

  assign newErr[0] = stEn & isRam & sizeOk & misaligned;
  assign newErr[1] = stEn & (~sizeOk | ~(isRam | mmioHit));
  assign newErr[2] = consWr & fifoFull & ~pop;

  assign ramWord  = mem[wordIdx];
  assign byteSel  = ramWord[{lane, 3'b000} +: 8];
  assign halfSel  = lane[1] ? ramWord[31:16] : ramWord[15:0];
  assign mtimeInc = mtime + 64'd1;

  always_comb begin
    dmemRdata = 32'd0;
    if (isRam) begin
      case (dmemSize)
        3'b000:  dmemRdata = {{24{byteSel[7]}}, byteSel};
        3'b100:  dmemRdata = {24'd0, byteSel};
        3'b001:  if (!lane[0]) dmemRdata = {{16{halfSel[15]}}, halfSel};
        3'b101:  if (!lane[0]) dmemRdata = {16'd0, halfSel};
        default: if (lane == 2'b00) dmemRdata = ramWord;
      endcase
    end else if (consHit) begin
      dmemRdata = {24'd0, cntLow, 2'b00, ~cons_valid, fifoFull};
    end else if (mtLoHit) begin
      dmemRdata = mtime[31:0];
    end else if (mtHiHit) begin
      dmemRdata = mtime[63:32];
    end else if (tohostHit) begin
      dmemRdata = {23'd0, done, exit_code};
    end else if (errHit) begin
      dmemRdata = {29'd0, err};
    end
  end

  always_comb begin
    byteEn   = 4'b1111;
    laneData = dmemWdata;
    case (dmemSize[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << lane;
        laneData = {4{dmemWdata[7:0]}};
      end
      2'b01: begin
        byteEn   = lane[1] ? 4'b1100 : 4'b0011;
        laneData = {2{dmemWdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ramWr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= dmemWdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // A half write replaces only its own half; the other half still advances.
  always_ff @(posedge clk) begin
    if (rst) mtime <= 64'd0;
    else     mtime <= {mtHiWr ? dmemWdata : mtimeInc[63:32], mtLoWr ? dmemWdata : mtimeInc[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 3'b000;
      done      <= 1'b0;
      exit_code <= 8'd0;
    end else begin
      err <= (errClr ? 3'b000 : err) | newErr;
      if (tohostWr && !done) begin
        done      <= 1'b1;
        exit_code <= dmemWdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM load/store lanes, error flags, console FIFO,
// MTIME wrap and TOHOST latch. Inputs change on the falling edge; checks sample there too.
module tb_dmem_responder;

  localparam logic [31:0] CONS   = 32'h8000_0000;
  localparam logic [31:0] MTLO   = 32'h8000_0004;
  localparam logic [31:0] MTHI   = 32'h8000_0008;
  localparam logic [31:0] TOHOST = 32'h8000_000C;
  localparam logic [31:0] ERRA   = 32'h8000_0010;
  localparam logic [2:0]  SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BU = 3'b100, SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmemAddr, dmemWdata, dmemRdata;
  logic [2:0]  dmemSize;
  logic        dmemWen;
  logic [7:0]  cons_data;
  logic        cons_valid, cons_ready;
  logic        done;
  logic [7:0]  exit_code;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemSize(dmemSize), .dmemWen(dmemWen),
    .dmemRdata(dmemRdata),
    .cons_data(cons_data), .cons_valid(cons_valid), .cons_ready(cons_ready),
    .done(done), .exit_code(exit_code), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the store lands on the following rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    dmemAddr  = a;
    dmemWdata = d;
    dmemSize  = s;
    dmemWen   = 1'b1;
    @(negedge clk);
    dmemWen   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] s, input logic [31:0] exp);
    dmemAddr = a;
    dmemSize = s;
    dmemWen  = 1'b0;
    #1;
    chk(tag, dmemRdata, exp);
  endtask

  initial begin
    rst = 1'b1; dmemAddr = 32'd0; dmemWdata = 32'd0; dmemSize = SZ_W; dmemWen = 1'b0; cons_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cons_valid", {31'd0, cons_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_exit_code", {24'd0, exit_code}, 32'd0);
    chk("rst_err", {29'd0, err}, 32'd0);

    rst = 1'b0; dmemAddr = MTLO;
    @(negedge clk);
    rd("mtime_first_cycle", MTLO, SZ_W, 32'd1);

    store(32'h100, 32'h8765_43A1, SZ_W);
    rd("lw_100",  32'h100, SZ_W,  32'h8765_43A1);
    rd("lb_100",  32'h100, SZ_B,  32'hFFFF_FFA1);
    rd("lbu_100", 32'h100, SZ_BU, 32'h0000_00A1);
    rd("lh_100",  32'h100, SZ_H,  32'h0000_43A1);
    rd("lhu_100", 32'h100, SZ_HU, 32'h0000_43A1);
    rd("lb_103",  32'h103, SZ_B,  32'hFFFF_FF87);
    rd("lh_102",  32'h102, SZ_H,  32'hFFFF_8765);
    rd("lw_misaligned", 32'h102, SZ_W, 32'd0);
    rd("lh_misaligned", 32'h101, SZ_H, 32'd0);
    rd("unmapped_read", 32'h1000_0000, SZ_W, 32'd0);

    store(32'h200, 32'h1122_3344, SZ_W);
    store(32'h201, 32'h0000_0055, SZ_B);
    rd("sb_lane1", 32'h200, SZ_W, 32'h1122_5544);
    store(32'h202, 32'h0000_BEEF, SZ_H);
    rd("sh_upper", 32'h200, SZ_W, 32'hBEEF_5544);

    store(32'h201, 32'h0000_7777, SZ_H);
    rd("sh_misaligned_nowrite", 32'h200, SZ_W, 32'hBEEF_5544);
    rd("err_misaligned", ERRA, SZ_W, 32'd1);
    store(ERRA, 32'd0, SZ_W);
    rd("err_cleared", ERRA, SZ_W, 32'd0);
    store(32'h9000_0000, 32'hDEAD_BEEF, SZ_W);
    rd("err_unmapped", ERRA, SZ_B, 32'd2);
    store(32'h200, 32'hDEAD_BEEF, 3'b011);
    rd("bad_size_nowrite", 32'h200, SZ_W, 32'hBEEF_5544);
    store(ERRA, 32'd0, SZ_W);

    cons_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(CONS, 32'h41 + i, SZ_B);
    rd("cons_status_full", CONS, SZ_W, 32'h0000_0081);
    rd("err_overflow", ERRA, SZ_W, 32'd4);
    chk("cons_head", {24'd0, cons_data}, 32'h41);
    cons_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_valid_%0d", i), {31'd0, cons_valid}, 32'd1);
      chk($sformatf("drain_data_%0d", i), {24'd0, cons_data}, 32'h41 + i);
      @(negedge clk);
    end
    cons_ready = 1'b0;
    chk("drain_empty", {31'd0, cons_valid}, 32'd0);
    rd("cons_status_empty", CONS, SZ_W, 32'h0000_0002);
    store(ERRA, 32'd0, SZ_W);

    store(MTHI, 32'd0, SZ_W);
    store(MTLO, 32'hFFFF_FFFF, SZ_W);
    rd("mtime_lo_written", MTLO, SZ_W, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("mtime_lo_wrap", MTLO, SZ_W, 32'd0);
    @(negedge clk);
    rd("mtime_hi_carry", MTHI, SZ_W, 32'd1);

    store(TOHOST, 32'h2A, SZ_W);
    store(TOHOST, 32'h07, SZ_W);
    chk("done_set", {31'd0, done}, 32'd1);
    chk("exit_code_first", {24'd0, exit_code}, 32'h2A);

    store(CONS, 32'h5A, SZ_B);
    chk("cons_before_rst", {31'd0, cons_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("done_after_rst", {31'd0, done}, 32'd0);
    chk("exit_after_rst", {24'd0, exit_code}, 32'd0);
    chk("fifo_flushed_by_rst", {31'd0, cons_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
